pipe_hazard_ctrl: RTL and testbench

//  Central pipeline sequencer for the 5-stage core. Generates stall/flush/redirect controls for PC, IF/ID, ID/EX and EX/MEM.

---
 rtl/pipe_hazard_ctrl.sv | 141 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer for the 5-stage core: turns load-use hazards, data-memory
// wait states and EX-stage redirects into stall/flush/PC-load controls.
module pipe_hazard_ctrl #(
  parameter int PC_WIDTH         = 32,
  parameter int REDIRECT_BUBBLES = 1,
  parameter int CNT_WIDTH        = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4:0]           id_rs1,
  input  logic [4:0]           id_rs2,
  input  logic                 id_rs1_used,
  input  logic                 id_rs2_used,
  input  logic                 ex_valid,
  input  logic                 ex_is_load,
  input  logic [4:0]           ex_rd,
  input  logic                 ex_redirect,
  input  logic [PC_WIDTH-1:0]  ex_target,
  input  logic                 dmem_req,
  input  logic                 dmem_ready,
  output logic                 pc_stall,
  output logic                 pc_load,
  output logic [PC_WIDTH-1:0]  pc_target,
  output logic                 if_id_stall,
  output logic                 if_id_flush,
  output logic                 id_ex_stall,
  output logic                 id_ex_flush,
  output logic                 ex_mem_stall,
  output logic [CNT_WIDTH-1:0] stall_cnt
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, FLUSH} state_t;

  localparam logic [2:0] BUB_RELOAD  = 3'(REDIRECT_BUBBLES);
  localparam state_t     AFTER_REDIR = (REDIRECT_BUBBLES > 0) ? FLUSH : RUN;

  state_t              state, state_nx;
  logic                pend_vld, pend_vld_nx;
  logic [PC_WIDTH-1:0] pend_tgt, pend_tgt_nx;
  logic [2:0]          bub_cnt, bub_cnt_nx;

  logic                hazard, memwait;
  logic                do_redir, do_stall_all, do_hazard, do_flush_only;
  logic [PC_WIDTH-1:0] redir_tgt;

  assign hazard = ex_valid & ex_is_load & (ex_rd != 5'd0) &
                  ((id_rs1_used & (id_rs1 == ex_rd)) | (id_rs2_used & (id_rs2 == ex_rd)));
  assign memwait = dmem_req & ~dmem_ready;

  always_comb begin
    state_nx      = state;
    pend_vld_nx   = pend_vld;
    pend_tgt_nx   = pend_tgt;
    bub_cnt_nx    = bub_cnt;
    do_redir      = 1'b0;
    do_stall_all  = 1'b0;
    do_hazard     = 1'b0;
    do_flush_only = 1'b0;
    redir_tgt     = ex_target;

    case (state)
      RUN: begin
        if (memwait) begin
          do_stall_all = 1'b1;
          state_nx     = MEM_WAIT;
          if (ex_redirect) begin
            pend_vld_nx = 1'b1;
            pend_tgt_nx = ex_target;
          end
        end else if (ex_redirect) begin
          do_redir = 1'b1;
        end else begin
          do_hazard = hazard;
        end
      end
      MEM_WAIT: begin
        if (memwait) begin
          do_stall_all = 1'b1;
          // EX is frozen while we wait, so the first redirect seen is the one to keep
          if (ex_redirect && !pend_vld) begin
            pend_vld_nx = 1'b1;
            pend_tgt_nx = ex_target;
          end
        end else begin
          pend_vld_nx = 1'b0;
          if (pend_vld || ex_redirect) begin
            do_redir  = 1'b1;
            redir_tgt = pend_vld ? pend_tgt : ex_target;
          end else begin
            do_hazard = hazard;
            state_nx  = RUN;
          end
        end
      end
      FLUSH: begin
        if (memwait) begin
          do_stall_all = 1'b1;
        end else if (ex_redirect) begin
          do_redir = 1'b1;
        end else begin
          do_flush_only = 1'b1;
          bub_cnt_nx    = bub_cnt - 3'd1;
          if (bub_cnt == 3'd1) state_nx = RUN;
        end
      end
      default: state_nx = RUN;
    endcase

    if (do_redir) begin
      bub_cnt_nx = BUB_RELOAD;
      state_nx   = AFTER_REDIR;
    end

    pc_stall     = (do_stall_all | do_hazard) & ~rst;
    pc_load      = do_redir & ~rst;
    pc_target    = (do_redir & ~rst) ? redir_tgt : '0;
    if_id_stall  = (do_stall_all | do_hazard) & ~rst;
    if_id_flush  = (do_redir | do_flush_only) & ~rst;
    id_ex_stall  = do_stall_all & ~rst;
    id_ex_flush  = (do_redir | do_hazard) & ~rst;
    ex_mem_stall = do_stall_all & ~rst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      pend_vld  <= 1'b0;
      pend_tgt  <= '0;
      bub_cnt   <= 3'd0;
      stall_cnt <= '0;
    end else begin
      state    <= state_nx;
      pend_vld <= pend_vld_nx;
      pend_tgt <= pend_tgt_nx;
      bub_cnt  <= bub_cnt_nx;
      if (pc_stall && (stall_cnt != {CNT_WIDTH{1'b1}}))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: vector table, hand-written multi-cycle sequences,
// and randomized traffic against a behavioural model on two parameterizations.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_rs1_used, id_rs2_used, ex_valid, ex_is_load, ex_redirect;
  logic [31:0] ex_target;
  logic        dmem_req, dmem_ready;

  logic        pc_stall, pc_load, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall;
  logic [31:0] pc_target;
  logic [3:0]  stall_cnt;
  logic        b_pc_stall, b_pc_load, b_if_id_stall, b_if_id_flush, b_id_ex_stall, b_id_ex_flush, b_ex_mem_stall;
  logic [31:0] b_pc_target;
  logic [15:0] b_stall_cnt;

  logic [6:0] ctrl, b_ctrl;
  assign ctrl   = {pc_stall, pc_load, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall};
  assign b_ctrl = {b_pc_stall, b_pc_load, b_if_id_stall, b_if_id_flush, b_id_ex_stall, b_id_ex_flush, b_ex_mem_stall};

  localparam logic [6:0] C_IDLE  = 7'b0000000;
  localparam logic [6:0] C_HAZ   = 7'b1010010;
  localparam logic [6:0] C_REDIR = 7'b0101010;
  localparam logic [6:0] C_STALL = 7'b1010101;
  localparam logic [6:0] C_FLUSH = 7'b0001000;

  pipe_hazard_ctrl #(.PC_WIDTH(32), .REDIRECT_BUBBLES(1), .CNT_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used),
    .id_rs2_used(id_rs2_used), .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
    .ex_redirect(ex_redirect), .ex_target(ex_target), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_stall(pc_stall), .pc_load(pc_load), .pc_target(pc_target), .if_id_stall(if_id_stall),
    .if_id_flush(if_id_flush), .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush),
    .ex_mem_stall(ex_mem_stall), .stall_cnt(stall_cnt));

  pipe_hazard_ctrl #(.PC_WIDTH(32), .REDIRECT_BUBBLES(3), .CNT_WIDTH(16)) dut_b (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used),
    .id_rs2_used(id_rs2_used), .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
    .ex_redirect(ex_redirect), .ex_target(ex_target), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_stall(b_pc_stall), .pc_load(b_pc_load), .pc_target(b_pc_target), .if_id_stall(b_if_id_stall),
    .if_id_flush(b_if_id_flush), .id_ex_stall(b_id_ex_stall), .id_ex_flush(b_id_ex_flush),
    .ex_mem_stall(b_ex_mem_stall), .stall_cnt(b_stall_cnt));

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  typedef struct {
    logic [4:0]  rs1, rs2;
    logic        u1, u2, ev, ld;
    logic [4:0]  rd;
    logic        redir;
    logic [31:0] tgt;
    logic        req, rdy;
    logic [6:0]  ectrl;
    logic [31:0] etgt;
  } vec_t;

  task automatic clear_in();
    id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0; ex_valid = 0; ex_is_load = 0;
    ex_rd = 0; ex_redirect = 0; ex_target = 0; dmem_req = 0; dmem_ready = 0;
  endtask

  task automatic apply(input vec_t v);
    id_rs1 = v.rs1; id_rs2 = v.rs2; id_rs1_used = v.u1; id_rs2_used = v.u2;
    ex_valid = v.ev; ex_is_load = v.ld; ex_rd = v.rd; ex_redirect = v.redir;
    ex_target = v.tgt; dmem_req = v.req; dmem_ready = v.rdy;
  endtask

  // Leaves the DUTs in RUN with rst released, just after a rising edge.
  task automatic do_reset();
    rst = 1'b1;
    clear_in();
    @(posedge clk); #1;
    chk("reset_ctrl", 32'(ctrl), 32'(C_IDLE));
    chk("reset_cnt", 32'(stall_cnt), 32'd0);
    rst = 1'b0;
  endtask

  // Behavioural reference: per instance, what the pipeline is doing now.
  int          m_bub [2];
  bit          m_wait[2];
  bit          m_pend[2];
  logic [31:0] m_pt  [2];
  int          m_cnt [2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_bub[k] = 0; m_wait[k] = 0; m_pend[k] = 0; m_pt[k] = 0; m_cnt[k] = 0;
    end
  endtask

  task automatic model_step(input int k, output logic [6:0] ec, output logic [31:0] et);
    bit mw, hz;
    int nbub, cmax;
    nbub = (k == 0) ? 1 : 3;
    cmax = (k == 0) ? 15 : 65535;
    mw = dmem_req && !dmem_ready;
    hz = ex_valid && ex_is_load && (ex_rd != 0) &&
         ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));
    ec = C_IDLE;
    et = 32'd0;
    if (rst) begin
      m_bub[k] = 0; m_wait[k] = 0; m_pend[k] = 0; m_pt[k] = 0; m_cnt[k] = 0;
    end else if (m_wait[k]) begin
      if (mw) begin
        ec = C_STALL;
        if (!m_pend[k] && ex_redirect) begin m_pend[k] = 1; m_pt[k] = ex_target; end
      end else begin
        m_wait[k] = 0;
        if (m_pend[k] || ex_redirect) begin
          ec = C_REDIR; et = m_pend[k] ? m_pt[k] : ex_target;
          m_pend[k] = 0; m_bub[k] = nbub;
        end else if (hz) ec = C_HAZ;
      end
    end else if (m_bub[k] > 0) begin
      if (mw) ec = C_STALL;
      else if (ex_redirect) begin ec = C_REDIR; et = ex_target; m_bub[k] = nbub; end
      else begin ec = C_FLUSH; m_bub[k]--; end
    end else begin
      if (mw) begin
        ec = C_STALL; m_wait[k] = 1;
        if (ex_redirect) begin m_pend[k] = 1; m_pt[k] = ex_target; end
      end else if (ex_redirect) begin ec = C_REDIR; et = ex_target; m_bub[k] = nbub; end
      else if (hz) ec = C_HAZ;
    end
    if (ec[6] && m_cnt[k] < cmax) m_cnt[k]++;
  endtask

  vec_t vecs[12];

  initial begin
    logic [6:0]  ec;
    logic [31:0] et;

    //            rs1 rs2 u1 u2 ev ld rd redir tgt      req rdy ectrl    etgt
    vecs[0]  = '{5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 32'h0,   0, 0, C_IDLE,  32'h0};
    vecs[1]  = '{5'd5, 5'd0, 1, 0, 1, 1, 5'd5, 0, 32'h0,   0, 0, C_HAZ,   32'h0};
    vecs[2]  = '{5'd1, 5'd7, 1, 1, 1, 1, 5'd7, 0, 32'h0,   0, 0, C_HAZ,   32'h0};
    vecs[3]  = '{5'd0, 5'd0, 1, 0, 1, 1, 5'd0, 0, 32'h0,   0, 0, C_IDLE,  32'h0};
    vecs[4]  = '{5'd2, 5'd9, 1, 0, 1, 1, 5'd9, 0, 32'h0,   0, 0, C_IDLE,  32'h0};
    vecs[5]  = '{5'd5, 5'd0, 1, 0, 0, 1, 5'd5, 0, 32'h0,   0, 0, C_IDLE,  32'h0};
    vecs[6]  = '{5'd5, 5'd0, 1, 0, 1, 0, 5'd5, 0, 32'h0,   0, 0, C_IDLE,  32'h0};
    vecs[7]  = '{5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 1, 32'h80,  0, 0, C_REDIR, 32'h80};
    vecs[8]  = '{5'd5, 5'd0, 1, 0, 1, 1, 5'd5, 1, 32'h44,  0, 0, C_REDIR, 32'h44};
    vecs[9]  = '{5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 32'h0,   1, 0, C_STALL, 32'h0};
    vecs[10] = '{5'd5, 5'd0, 1, 0, 1, 1, 5'd5, 1, 32'h90,  1, 0, C_STALL, 32'h0};
    vecs[11] = '{5'd3, 5'd0, 1, 0, 1, 1, 5'd3, 0, 32'h0,   1, 1, C_HAZ,   32'h0};

    for (int i = 0; i < 12; i++) begin
      do_reset();
      apply(vecs[i]);
      @(negedge clk);
      chk($sformatf("vec%0d_ctrl", i), 32'(ctrl), 32'(vecs[i].ectrl));
      chk($sformatf("vec%0d_tgt", i), pc_target, vecs[i].etgt);
    end

    // Load-use stall lasts one cycle once the bubble reaches EX
    do_reset();
    id_rs1 = 5; id_rs1_used = 1; ex_valid = 1; ex_is_load = 1; ex_rd = 5;
    @(negedge clk); chk("lu_stall", 32'(ctrl), 32'(C_HAZ));
    @(posedge clk); #1; ex_valid = 0;
    @(negedge clk); chk("lu_after", 32'(ctrl), 32'(C_IDLE));

    // Redirect followed by one extra IF/ID flush
    do_reset();
    ex_redirect = 1; ex_target = 32'h80;
    @(negedge clk); chk("rd_n_ctrl", 32'(ctrl), 32'(C_REDIR)); chk("rd_n_tgt", pc_target, 32'h80);
    @(posedge clk); #1; ex_redirect = 0; ex_target = 0;
    @(negedge clk); chk("rd_n1_ctrl", 32'(ctrl), 32'(C_FLUSH));
    @(posedge clk); #1;
    @(negedge clk); chk("rd_n2_ctrl", 32'(ctrl), 32'(C_IDLE));

    // Memory wait with a held redirect
    do_reset();
    dmem_req = 1; dmem_ready = 0; ex_redirect = 1; ex_target = 32'h200;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk($sformatf("mw_stall%0d", i), 32'(ctrl), 32'(C_STALL));
      @(posedge clk); #1;
    end
    dmem_ready = 1;
    @(negedge clk);
    chk("mw_exit_ctrl", 32'(ctrl), 32'(C_REDIR));
    chk("mw_exit_tgt", pc_target, 32'h200);
    chk("mw_exit_cnt", 32'(stall_cnt), 32'd3);
    @(posedge clk); #1; clear_in();
    @(negedge clk); chk("mw_flush", 32'(ctrl), 32'(C_FLUSH));

    // Stall counter saturation
    do_reset();
    dmem_req = 1; dmem_ready = 0;
    repeat (20) @(posedge clk);
    #1; chk("sat_cnt", 32'(stall_cnt), 32'd15);

    // Reset in the middle of a wait with a pending redirect
    do_reset();
    dmem_req = 1; dmem_ready = 0; ex_redirect = 1; ex_target = 32'h300;
    repeat (2) @(posedge clk);
    #1; rst = 1;
    @(negedge clk); chk("rst_mw_ctrl", 32'(ctrl), 32'(C_IDLE)); chk("rst_mw_tgt", pc_target, 32'h0);
    @(posedge clk); #1; rst = 0; ex_redirect = 0; dmem_ready = 1;
    @(negedge clk); chk("rst_rel_ctrl", 32'(ctrl), 32'(C_IDLE)); chk("rst_rel_cnt", 32'(stall_cnt), 32'd0);

    // Randomized traffic against the reference model, both parameterizations
    @(posedge clk); #1;
    do_reset();
    model_reset();
    for (int c = 0; c < 600; c++) begin
      rst         = ($urandom_range(0, 59) == 0);
      id_rs1      = 5'($urandom_range(0, 3));
      id_rs2      = 5'($urandom_range(0, 3));
      id_rs1_used = 1'($urandom);
      id_rs2_used = 1'($urandom);
      ex_valid    = ($urandom_range(0, 3) != 0);
      ex_is_load  = 1'($urandom);
      ex_rd       = 5'($urandom_range(0, 3));
      ex_redirect = ($urandom_range(0, 5) == 0);
      ex_target   = $urandom;
      dmem_req    = ($urandom_range(0, 2) == 0);
      dmem_ready  = 1'($urandom);
      @(negedge clk);
      chk("rnd_a_cnt", 32'(stall_cnt), 32'(m_cnt[0]));
      model_step(0, ec, et);
      chk("rnd_a_ctrl", 32'(ctrl), 32'(ec));
      chk("rnd_a_tgt", pc_target, et);
      chk("rnd_b_cnt", 32'(b_stall_cnt), 32'(m_cnt[1]));
      model_step(1, ec, et);
      chk("rnd_b_ctrl", 32'(b_ctrl), 32'(ec));
      chk("rnd_b_tgt", b_pc_target, et);
      @(posedge clk); #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
